// File: rtl/spi_reg_master.sv
// Mode-0 SPI master: one register read/write/fastcmd per request handshake.
// Frame is {op,addr} MSB first plus REG_W data bits (none for fastcmd); status returns during the command byte.
module spi_reg_master #(
    parameter int REG_W   = 8,
    parameter int CLK_DIV = 4
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [1:0]       req_op,
    input  logic [5:0]       req_addr,
    input  logic [REG_W-1:0] req_wdata,
    output logic             rsp_valid,
    output logic [7:0]       rsp_status,
    output logic [REG_W-1:0] rsp_rdata,
    output logic             sclk,
    output logic             mosi,
    input  logic             miso,
    output logic             nss
);
    localparam int FW = 8 + REG_W;
    localparam int CW = $clog2(CLK_DIV) + 1;
    localparam int BW = $clog2(FW) + 1;
    localparam logic [CW-1:0] HALF_RELOAD = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] GAP_RELOAD  = CW'(2 * CLK_DIV - 1);
    localparam logic [BW-1:0] LAST_FULL   = BW'(FW - 1);
    localparam logic [BW-1:0] LAST_FAST   = BW'(7);

    generate
        if (CLK_DIV < 4) begin : g_bad_div
            $error("spi_reg_master: CLK_DIV must be >= 4");
        end
        if (REG_W < 8 || (REG_W % 8) != 0) begin : g_bad_width
            $error("spi_reg_master: REG_W must be a non-zero multiple of 8");
        end
    endgenerate

    typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_t;

    state_t           state;
    logic [CW-1:0]    half_cnt;
    logic [BW-1:0]    bit_cnt;
    logic [FW-2:0]    tx_sr;
    logic [FW-1:0]    rx_sr;
    logic             fast;
    logic [1:0]       miso_sync;
    logic [1:0]       op_eff;
    logic [REG_W-1:0] wdata_eff;

    // Reserved op 01 goes out as a plain read; only writes carry real data bits.
    assign op_eff    = (req_op == 2'b01) ? 2'b00 : req_op;
    assign wdata_eff = (op_eff == 2'b10) ? req_wdata : '0;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            miso_sync <= '0;
        end else begin
            miso_sync <= {miso_sync[0], miso};
        end
    end

    // tx_sr holds the bits after the one currently on mosi, so mosi leads the shift register.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state      <= IDLE;
            req_ready  <= 1'b1;
            rsp_valid  <= 1'b0;
            rsp_status <= '0;
            rsp_rdata  <= '0;
            sclk       <= 1'b0;
            mosi       <= 1'b0;
            nss        <= 1'b1;
            half_cnt   <= '0;
            bit_cnt    <= '0;
            tx_sr      <= '0;
            rx_sr      <= '0;
            fast       <= 1'b0;
        end else begin
            rsp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid && req_ready) begin
                        state     <= SETUP;
                        req_ready <= 1'b0;
                        nss       <= 1'b0;
                        mosi      <= op_eff[1];
                        tx_sr     <= {op_eff[0], req_addr, wdata_eff};
                        rx_sr     <= '0;
                        fast      <= (op_eff == 2'b11);
                        half_cnt  <= HALF_RELOAD;
                        bit_cnt   <= '0;
                    end
                end
                SETUP: begin
                    if (half_cnt == '0) begin
                        sclk     <= 1'b1;
                        half_cnt <= HALF_RELOAD;
                        state    <= SHIFT;
                    end else begin
                        half_cnt <= half_cnt - CW'(1);
                    end
                end
                SHIFT: begin
                    if (half_cnt == '0) begin
                        half_cnt <= HALF_RELOAD;
                        if (!sclk) begin
                            sclk <= 1'b1;
                        end else begin
                            // Falling edge: sample miso at the end of the high phase, then advance mosi.
                            sclk    <= 1'b0;
                            rx_sr   <= {rx_sr[FW-2:0], miso_sync[1]};
                            mosi    <= tx_sr[FW-2];
                            tx_sr   <= {tx_sr[FW-3:0], 1'b0};
                            bit_cnt <= bit_cnt + BW'(1);
                            if (bit_cnt == (fast ? LAST_FAST : LAST_FULL)) begin
                                state <= HOLD;
                            end
                        end
                    end else begin
                        half_cnt <= half_cnt - CW'(1);
                    end
                end
                HOLD: begin
                    if (half_cnt == '0) begin
                        nss        <= 1'b1;
                        mosi       <= 1'b0;
                        rsp_valid  <= 1'b1;
                        rsp_status <= fast ? rx_sr[7:0] : rx_sr[FW-1:REG_W];
                        rsp_rdata  <= fast ? '0 : rx_sr[REG_W-1:0];
                        half_cnt   <= GAP_RELOAD;
                        state      <= GAP;
                    end else begin
                        half_cnt <= half_cnt - CW'(1);
                    end
                end
                GAP: begin
                    if (half_cnt == '0) begin
                        req_ready <= 1'b1;
                        state     <= IDLE;
                    end else begin
                        half_cnt <= half_cnt - CW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
